// File: rtl/debounce_pkg.sv
// Shared FSM state encoding and default timing constants for the
// debounced auto-repeat button.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      REPEAT  = 2'd2
   } state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_REPEAT_DELAY    = 64;
   localparam int DEF_REPEAT_PERIOD   = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both stages
// reset to 0 so a held input is re-qualified after every reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/debounce_pulse.sv
// Debounces a raw button and turns accepted presses into single-cycle
// strobes, with optional auto-repeat while the button stays held.
module debounce_pulse
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   input  logic repeat_en,
   output logic pulse,
   output logic btn_level,
   output logic repeating
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES - 1) + 1;
   localparam int RP_W = $clog2(REPEAT_DELAY - 1) + 1;
   localparam logic [DB_W-1:0] DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] DELAY_MAX = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] PER_MAX   = RP_W'(REPEAT_PERIOD - 1);

   generate
      if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
         $error("debounce_pulse: DEBOUNCE_CYCLES must be at least 2");
      end
      if (REPEAT_PERIOD < 2) begin : g_chk_per
         $error("debounce_pulse: REPEAT_PERIOD must be at least 2");
      end
      if (REPEAT_DELAY < REPEAT_PERIOD) begin : g_chk_dly
         $error("debounce_pulse: REPEAT_DELAY must be >= REPEAT_PERIOD");
      end
   endgenerate

   logic            btn_sync;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            level_q, level_d;
   logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic            pulse_q, pulse_d;
   state_e          state_q, state_d;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (btn_in),
      .q     (btn_sync)
   );

   always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (btn_sync != level_q) begin
         if (db_cnt_q == DB_MAX) begin
            level_d = ~level_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   // The FSM looks at the next debounced level so the press strobe lines up
   // with the btn_level rise and a release suppresses any repeat due that cycle.
   always_comb begin
      state_d   = state_q;
      rep_cnt_d = rep_cnt_q;
      pulse_d   = 1'b0;
      case (state_q)
         IDLE: begin
            rep_cnt_d = '0;
            if (level_d) begin
               state_d = PRESSED;
               pulse_d = 1'b1;
            end
         end
         PRESSED: begin
            if (!level_d) begin
               state_d   = IDLE;
               rep_cnt_d = '0;
            end else if (!repeat_en) begin
               rep_cnt_d = '0;
            end else if (rep_cnt_q == DELAY_MAX) begin
               state_d   = REPEAT;
               rep_cnt_d = '0;
               pulse_d   = 1'b1;
            end else begin
               rep_cnt_d = rep_cnt_q + RP_W'(1);
            end
         end
         REPEAT: begin
            if (!level_d) begin
               state_d   = IDLE;
               rep_cnt_d = '0;
            end else if (!repeat_en) begin
               state_d   = PRESSED;
               rep_cnt_d = '0;
            end else if (rep_cnt_q == PER_MAX) begin
               rep_cnt_d = '0;
               pulse_d   = 1'b1;
            end else begin
               rep_cnt_d = rep_cnt_q + RP_W'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            rep_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         rep_cnt_q <= '0;
         pulse_q   <= 1'b0;
         state_q   <= IDLE;
      end else begin
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         rep_cnt_q <= rep_cnt_d;
         pulse_q   <= pulse_d;
         state_q   <= state_d;
      end
   end

   assign pulse     = pulse_q;
   assign btn_level = level_q;
   assign repeating = (state_q == REPEAT);

endmodule
